// File: rtl/fpu_wb_collector_pkg.sv
// fpu_wb_collector_pkg
// Shared widths for the FPU writeback collector. The control sideband widths
// use the usual project values.
package fpu_wb_collector_pkg;

    localparam int REGIDX_W = 5;
    localparam int REGEXT_W = 3;
    localparam int WARP_W   = 3;

    // Register index carried on the writeback ports (index + extension bits).
    localparam int REG_W    = REGIDX_W + REGEXT_W;
    // IEEE exception flags per lane: NV, DZ, OF, UF, NX.
    localparam int FFLAGS_W = 5;

endpackage

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo
// Generic DEPTH x WIDTH stream FIFO with a combinational head read.
// The head word reads as zero while the FIFO is empty so downstream data
// outputs are quiet without extra gating.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write strobe and word (ignored when full)
//   pop_i             retire the head word (ignored when empty)
//   head_o            current head word, 0 when empty
//   full_o, empty_o   occupancy status from registered state only
module fpu_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    import fpu_wb_collector_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: a word is only observable after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fpu_wb_collector.sv
// fpu_wb_collector
// Collects completed FPU lane-group results, buffers them, and hands each
// entry to the vector writeback port, the scalar writeback port, or both.
// Also reports the masked OR of lane exception flags as each entry retires.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid_i / in_ready_o         FPU result handshake (ready = not full)
//   in_result_i, in_fflags_i        per-lane results and exception flags
//   ctrl_*_i                        register index, warp, lane mask, wvd, wxd
//   out_v_*                         vector writeback handshake and data
//   out_x_*                         scalar writeback handshake and data
//   fflags_valid_o, fflags_o        one-cycle pulse per retired entry
module fpu_wb_collector
    import fpu_wb_collector_pkg::*;
#(
    parameter int EXPWIDTH    = 8,
    parameter int PRECISION   = 24,
    parameter int SOFT_THREAD = 4,
    parameter int DEPTH       = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid_i,
    output logic                                       in_ready_o,
    input  logic [SOFT_THREAD*(EXPWIDTH+PRECISION)-1:0] in_result_i,
    input  logic [SOFT_THREAD*FFLAGS_W-1:0]            in_fflags_i,
    input  logic [REG_W-1:0]                           ctrl_regindex_i,
    input  logic [WARP_W-1:0]                          ctrl_warpid_i,
    input  logic [SOFT_THREAD-1:0]                     ctrl_vecmask_i,
    input  logic                                       ctrl_wvd_i,
    input  logic                                       ctrl_wxd_i,
    output logic                                       out_v_valid_o,
    input  logic                                       out_v_ready_i,
    output logic [SOFT_THREAD*(EXPWIDTH+PRECISION)-1:0] out_v_result_o,
    output logic [SOFT_THREAD-1:0]                     out_v_mask_o,
    output logic [REG_W-1:0]                           out_v_regindex_o,
    output logic [WARP_W-1:0]                          out_v_warpid_o,
    output logic                                       out_x_valid_o,
    input  logic                                       out_x_ready_i,
    output logic [EXPWIDTH+PRECISION-1:0]              out_x_result_o,
    output logic [REG_W-1:0]                           out_x_regindex_o,
    output logic [WARP_W-1:0]                          out_x_warpid_o,
    output logic                                       fflags_valid_o,
    output logic [FFLAGS_W-1:0]                        fflags_o
);

    localparam int LEN   = EXPWIDTH + PRECISION;
    localparam int RES_W = SOFT_THREAD * LEN;
    localparam int FF_W  = SOFT_THREAD * FFLAGS_W;
    localparam int ENT_W = RES_W + FF_W + REG_W + WARP_W + SOFT_THREAD + 2;

    logic [ENT_W-1:0]       entry_in, head;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;

    logic [RES_W-1:0]       h_result;
    logic [FF_W-1:0]        h_fflags;
    logic [REG_W-1:0]       h_regindex;
    logic [WARP_W-1:0]      h_warpid;
    logic [SOFT_THREAD-1:0] h_mask;
    logic                   h_wvd, h_wxd;

    logic                   sent_v_q, sent_v_d;
    logic                   sent_x_q, sent_x_d;
    logic                   v_fire, x_fire, done_v, done_x;

    logic [FFLAGS_W-1:0]    lane_ff [SOFT_THREAD];
    logic [LEN-1:0]         x_sel;
    logic [FFLAGS_W-1:0]    ff_or;

    assign entry_in = {in_result_i, in_fflags_i, ctrl_regindex_i, ctrl_warpid_i,
                       ctrl_vecmask_i, ctrl_wvd_i, ctrl_wxd_i};

    // Ready depends only on FIFO occupancy, so a writeback stall never
    // reaches back into the FPU pipeline combinationally.
    assign in_ready_o = !fifo_full;
    assign push       = in_valid_i && in_ready_o;

    fpu_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (entry_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head reads as zero when empty, so every field below is zero then too.
    assign {h_result, h_fflags, h_regindex, h_warpid, h_mask, h_wvd, h_wxd} = head;

    // Each port fires once per entry; the sent flag remembers an early
    // accept while the other port is still waiting.
    assign out_v_valid_o = !fifo_empty && h_wvd && !sent_v_q;
    assign out_x_valid_o = !fifo_empty && h_wxd && !sent_x_q;
    assign v_fire        = out_v_valid_o && out_v_ready_i;
    assign x_fire        = out_x_valid_o && out_x_ready_i;
    assign done_v        = !h_wvd || sent_v_q || v_fire;
    assign done_x        = !h_wxd || sent_x_q || x_fire;
    assign pop           = !fifo_empty && done_v && done_x;

    assign sent_v_d = pop ? 1'b0 : (sent_v_q || v_fire);
    assign sent_x_d = pop ? 1'b0 : (sent_x_q || x_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_v_q <= 1'b0;
            sent_x_q <= 1'b0;
        end else begin
            sent_v_q <= sent_v_d;
            sent_x_q <= sent_x_d;
        end
    end

    // Per-lane flags gated by the active-lane mask.
    for (genvar gi = 0; gi < SOFT_THREAD; gi++) begin : g_lane_ff
        assign lane_ff[gi] = h_mask[gi] ? h_fflags[gi*FFLAGS_W +: FFLAGS_W] : '0;
    end

    always_comb begin
        ff_or = '0;
        for (int i = 0; i < SOFT_THREAD; i++) begin
            ff_or = ff_or | lane_ff[i];
        end
    end

    // Scalar result comes from the lowest active lane; lane 0 if none active.
    always_comb begin
        x_sel = h_result[0 +: LEN];
        for (int i = SOFT_THREAD - 1; i >= 0; i--) begin
            if (h_mask[i]) x_sel = h_result[i*LEN +: LEN];
        end
    end

    assign out_v_result_o   = h_result;
    assign out_v_mask_o     = h_mask;
    assign out_v_regindex_o = h_regindex;
    assign out_v_warpid_o   = h_warpid;
    assign out_x_result_o   = x_sel;
    assign out_x_regindex_o = h_regindex;
    assign out_x_warpid_o   = h_warpid;
    assign fflags_valid_o   = pop;
    assign fflags_o         = ff_or;

endmodule

// File: tb/tb_fpu_wb_collector.sv
module tb_fpu_wb_collector;
    import fpu_wb_collector_pkg::*;

    localparam int EXPW  = 8;
    localparam int PREC  = 24;
    localparam int ST    = 4;
    localparam int DEPTH = 2;
    localparam int LEN   = EXPW + PREC;
    localparam int RES_W = ST * LEN;
    localparam int FF_W  = ST * FFLAGS_W;

    typedef struct packed {
        logic [RES_W-1:0]  res;
        logic [ST-1:0]     mask;
        logic [REG_W-1:0]  ridx;
        logic [WARP_W-1:0] warp;
    } v_exp_t;

    typedef struct packed {
        logic [LEN-1:0]    res;
        logic [REG_W-1:0]  ridx;
        logic [WARP_W-1:0] warp;
    } x_exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [RES_W-1:0]    in_result_i = '0;
    logic [FF_W-1:0]     in_fflags_i = '0;
    logic [REG_W-1:0]    ctrl_regindex_i = '0;
    logic [WARP_W-1:0]   ctrl_warpid_i = '0;
    logic [ST-1:0]       ctrl_vecmask_i = '0;
    logic                ctrl_wvd_i = 1'b0;
    logic                ctrl_wxd_i = 1'b0;
    logic                out_v_valid_o;
    logic                out_v_ready_i = 1'b0;
    logic [RES_W-1:0]    out_v_result_o;
    logic [ST-1:0]       out_v_mask_o;
    logic [REG_W-1:0]    out_v_regindex_o;
    logic [WARP_W-1:0]   out_v_warpid_o;
    logic                out_x_valid_o;
    logic                out_x_ready_i = 1'b0;
    logic [LEN-1:0]      out_x_result_o;
    logic [REG_W-1:0]    out_x_regindex_o;
    logic [WARP_W-1:0]   out_x_warpid_o;
    logic                fflags_valid_o;
    logic [FFLAGS_W-1:0] fflags_o;

    fpu_wb_collector #(
        .EXPWIDTH    (EXPW),
        .PRECISION   (PREC),
        .SOFT_THREAD (ST),
        .DEPTH       (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_result_i      (in_result_i),
        .in_fflags_i      (in_fflags_i),
        .ctrl_regindex_i  (ctrl_regindex_i),
        .ctrl_warpid_i    (ctrl_warpid_i),
        .ctrl_vecmask_i   (ctrl_vecmask_i),
        .ctrl_wvd_i       (ctrl_wvd_i),
        .ctrl_wxd_i       (ctrl_wxd_i),
        .out_v_valid_o    (out_v_valid_o),
        .out_v_ready_i    (out_v_ready_i),
        .out_v_result_o   (out_v_result_o),
        .out_v_mask_o     (out_v_mask_o),
        .out_v_regindex_o (out_v_regindex_o),
        .out_v_warpid_o   (out_v_warpid_o),
        .out_x_valid_o    (out_x_valid_o),
        .out_x_ready_i    (out_x_ready_i),
        .out_x_result_o   (out_x_result_o),
        .out_x_regindex_o (out_x_regindex_o),
        .out_x_warpid_o   (out_x_warpid_o),
        .fflags_valid_o   (fflags_valid_o),
        .fflags_o         (fflags_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tag    = 1;
    v_exp_t              qv[$];
    x_exp_t              qx[$];
    logic [FFLAGS_W-1:0] qf[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: scan from the top lane down so the last hit is the lowest set lane.
    function automatic logic [LEN-1:0] ref_xres(input logic [RES_W-1:0] r, input logic [ST-1:0] m);
        logic [LEN-1:0] v;
        v = r[LEN-1:0];
        for (int i = ST - 1; i >= 0; i--)
            if (m[i]) v = r[i*LEN +: LEN];
        return v;
    endfunction

    function automatic logic [FFLAGS_W-1:0] ref_ff(input logic [FF_W-1:0] f, input logic [ST-1:0] m);
        logic [FFLAGS_W-1:0] v;
        v = '0;
        for (int i = 0; i < ST; i++)
            if (m[i]) v = v | f[i*FFLAGS_W +: FFLAGS_W];
        return v;
    endfunction

    // Present one entry and hold it until accepted; expectations are queued
    // at the cycle the push happens. Returns with in_valid still high.
    task automatic drive(input logic [RES_W-1:0] res, input logic [FF_W-1:0] ff,
                         input logic [ST-1:0] mask, input logic wvd, input logic wxd,
                         output int waits);
        bit ok;
        v_exp_t ev;
        x_exp_t ex;
        ok = 0;
        waits = 0;
        in_result_i     = res;
        in_fflags_i     = ff;
        ctrl_vecmask_i  = mask;
        ctrl_wvd_i      = wvd;
        ctrl_wxd_i      = wxd;
        ctrl_regindex_i = REG_W'(tag);
        ctrl_warpid_i   = WARP_W'(tag >> 1);
        in_valid_i      = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready_o) begin
                ok = 1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            chk("push_timeout", 1, 0);
        end else begin
            ev.res = res; ev.mask = mask; ev.ridx = REG_W'(tag); ev.warp = WARP_W'(tag >> 1);
            ex.res = ref_xres(res, mask); ex.ridx = REG_W'(tag); ex.warp = WARP_W'(tag >> 1);
            if (wvd) qv.push_back(ev);
            if (wxd) qx.push_back(ex);
            qf.push_back(ref_ff(ff, mask));
            $display("push tag=%0d wvd=%0b wxd=%0b mask=%b waits=%0d", tag, wvd, wxd, mask, waits);
        end
        tag++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: data must match the queue head for as long as
    // valid is up, and the entry is consumed on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_v_valid_o) begin
                if (qv.size() == 0) chk("v_unexpected", 1, 0);
                else begin
                    chk("v_result", out_v_result_o, qv[0].res);
                    chk("v_mask", out_v_mask_o, qv[0].mask);
                    chk("v_regidx", out_v_regindex_o, qv[0].ridx);
                    chk("v_warp", out_v_warpid_o, qv[0].warp);
                    if (out_v_ready_i) begin
                        $display("v accept reg=%0h warp=%0h mask=%b", out_v_regindex_o, out_v_warpid_o, out_v_mask_o);
                        void'(qv.pop_front());
                    end
                end
            end
            if (out_x_valid_o) begin
                if (qx.size() == 0) chk("x_unexpected", 1, 0);
                else begin
                    chk("x_result", out_x_result_o, qx[0].res);
                    chk("x_regidx", out_x_regindex_o, qx[0].ridx);
                    chk("x_warp", out_x_warpid_o, qx[0].warp);
                    if (out_x_ready_i) begin
                        $display("x accept reg=%0h res=%h", out_x_regindex_o, out_x_result_o);
                        void'(qx.pop_front());
                    end
                end
            end
            if (fflags_valid_o) begin
                if (qf.size() == 0) chk("ff_unexpected", 1, 0);
                else begin
                    chk("fflags", fflags_o, qf[0]);
                    $display("retire fflags=%b", fflags_o);
                    void'(qf.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_v_valid", out_v_valid_o, 0);
        chk("rst_x_valid", out_x_valid_o, 0);
        chk("rst_ff_valid", fflags_valid_o, 0);
        chk("rst_v_result", out_v_result_o, 0);
        chk("rst_x_result", out_x_result_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: vector-only entry, all lanes active, readies held high.
        out_v_ready_i = 1'b1; out_x_ready_i = 1'b1;
        drive({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
              {5'h08, 5'h04, 5'h02, 5'h01}, 4'b1111, 1'b1, 1'b0, w);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("t1_v_valid", out_v_valid_o, 1);
        chk("t1_x_valid", out_x_valid_o, 0);
        chk("t1_ff_valid", fflags_valid_o, 1);
        chk("t1_fflags", fflags_o, 5'h0F);
        @(negedge clk);
        chk("t1_v_after", out_v_valid_o, 0);
        chk("t1_ff_after", fflags_valid_o, 0);
        idle(1);

        // 2: both ports, scalar accepts first, vector stalled 3 cycles.
        out_v_ready_i = 1'b0; out_x_ready_i = 1'b1;
        drive({32'hC0000000, 32'h3F800000, 32'h40000000, 32'h40400000},
              {5'h00, 5'h04, 5'h00, 5'h10}, 4'b0100, 1'b1, 1'b1, w);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_x_valid", out_x_valid_o, 1);
        chk("t2_x_result", out_x_result_o, 32'h3F800000);
        chk("t2_v_valid0", out_v_valid_o, 1);
        chk("t2_no_retire", fflags_valid_o, 0);
        @(negedge clk);
        chk("t2_x_done", out_x_valid_o, 0);
        chk("t2_v_valid1", out_v_valid_o, 1);
        @(negedge clk);
        chk("t2_v_valid2", out_v_valid_o, 1);
        @(posedge clk); #1;
        out_v_ready_i = 1'b1;
        @(negedge clk);
        chk("t2_ff_valid", fflags_valid_o, 1);
        chk("t2_fflags", fflags_o, 5'h04);
        @(negedge clk);
        chk("t2_v_after", out_v_valid_o, 0);
        idle(1);

        // 3: fill with vector port stalled, third entry held off.
        out_v_ready_i = 1'b0; out_x_ready_i = 1'b1;
        drive({4{32'hA0000001}}, '0, 4'b0011, 1'b1, 1'b0, w);
        drive({4{32'hA0000002}}, '0, 4'b1000, 1'b1, 1'b0, w);
        in_result_i = {4{32'hA0000003}};
        @(negedge clk);
        chk("t3_full0", in_ready_o, 0);
        @(negedge clk);
        chk("t3_full1", in_ready_o, 0);
        @(posedge clk); #1;
        out_v_ready_i = 1'b1;
        drive({4{32'hA0000003}}, '0, 4'b0101, 1'b1, 1'b0, w);
        chk("t3_third_wait", w, 1);
        idle(4);
        chk("t3_drained", qv.size(), 0);

        // 4: streaming, one entry per cycle, wraps the pointers several times.
        out_v_ready_i = 1'b1; out_x_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive({$urandom, $urandom, $urandom, $urandom}, FF_W'($urandom),
                  ST'($urandom_range(0, 15)), 1'b1, i[0], w);
            chk("t4_stream_wait", w, 0);
        end
        idle(3);
        chk("t4_v_drained", qv.size(), 0);
        chk("t4_x_drained", qx.size(), 0);

        // 5: no writeback at all, only the flags report.
        drive({4{32'h5555AAAA}}, {5'h10, 5'h10, 5'h10, 5'h01}, 4'b0001, 1'b0, 1'b0, w);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_v_valid", out_v_valid_o, 0);
        chk("t5_x_valid", out_x_valid_o, 0);
        chk("t5_ff_valid", fflags_valid_o, 1);
        chk("t5_fflags", fflags_o, 5'h01);
        @(negedge clk);
        chk("t5_ff_after", fflags_valid_o, 0);
        idle(1);

        // 6: asynchronous reset with two entries queued.
        out_v_ready_i = 1'b0; out_x_ready_i = 1'b0;
        drive({4{32'h0BADF00D}}, '0, 4'b1111, 1'b1, 1'b1, w);
        drive({4{32'h0BADBEEF}}, '0, 4'b1111, 1'b1, 1'b1, w);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("t6_pre_ready", in_ready_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_v_valid", out_v_valid_o, 0);
        chk("t6_x_valid", out_x_valid_o, 0);
        chk("t6_in_ready", in_ready_o, 1);
        chk("t6_v_result", out_v_result_o, 0);
        qv.delete(); qx.delete(); qf.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_v_ready_i = 1'b1; out_x_ready_i = 1'b1;
        @(negedge clk);
        chk("t6_post_v", out_v_valid_o, 0);
        chk("t6_post_x", out_x_valid_o, 0);
        chk("t6_post_ff", fflags_valid_o, 0);
        idle(3);

        chk("end_qv", qv.size(), 0);
        chk("end_qx", qx.size(), 0);
        chk("end_qf", qf.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
